// File: rtl/mux2_rr_arbiter_8bit.sv
// Round-robin 2:1 byte arbiter with bounded bursts and a 1-deep registered output stage.
// Optional per-source beat counters are enabled by defining MUX2_ARB_CNT_EN.
module mux2_rr_arbiter_8bit #(
    parameter int BURST_LEN = 2,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x_valid,
    input  logic [7:0]       x_data,
    output logic             x_ready,
    input  logic             y_valid,
    input  logic [7:0]       y_data,
    output logic             y_ready,
    output logic             m_valid,
    output logic [7:0]       m_data,
    output logic             m_src,
    input  logic             m_ready,
`ifdef MUX2_ARB_CNT_EN
    output logic [CNT_W-1:0] x_cnt,
    output logic [CNT_W-1:0] y_cnt,
`endif
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, OWN_X, OWN_Y} state_t;

    localparam logic [3:0] BURST_MAX = 4'(BURST_LEN);

    state_t     state_q;
    logic       last_q;
    logic [3:0] burst_q;
    logic       m_valid_q;
    logic [7:0] m_data_q;
    logic       m_src_q;

    logic       slot_free;
    logic       gnt_x, gnt_y;
    logic       acc_x, acc_y;
    logic [3:0] burst_inc;

    assign slot_free = !m_valid_q || m_ready;

    // Grant is a pure function of ownership and current valids; the slot check gates it below.
    always_comb begin
        gnt_x = 1'b0;
        gnt_y = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (x_valid && (!y_valid || last_q)) gnt_x = 1'b1;
                else if (y_valid)                    gnt_y = 1'b1;
            end
            OWN_X: begin
                if (!y_valid)                                gnt_x = 1'b1;
                else if (!x_valid || burst_q >= BURST_MAX)   gnt_y = 1'b1;
                else                                         gnt_x = 1'b1;
            end
            OWN_Y: begin
                if (!x_valid)                                gnt_y = 1'b1;
                else if (!y_valid || burst_q >= BURST_MAX)   gnt_x = 1'b1;
                else                                         gnt_y = 1'b1;
            end
            default: ;
        endcase
    end

    assign x_ready   = gnt_x && slot_free && !rst;
    assign y_ready   = gnt_y && slot_free && !rst;
    assign acc_x     = x_valid && x_ready;
    assign acc_y     = y_valid && y_ready;
    assign burst_inc = (burst_q >= BURST_MAX) ? BURST_MAX : burst_q + 4'd1;

    // Ownership FSM; frozen while the output stage is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            burst_q <= 4'd0;
        end else if (slot_free) begin
            if (acc_x) begin
                state_q <= OWN_X;
                last_q  <= 1'b0;
                burst_q <= (state_q == OWN_X) ? burst_inc : 4'd1;
            end else if (acc_y) begin
                state_q <= OWN_Y;
                last_q  <= 1'b1;
                burst_q <= (state_q == OWN_Y) ? burst_inc : 4'd1;
            end else if (!x_valid && !y_valid) begin
                state_q <= IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            m_data_q  <= 8'h00;
            m_src_q   <= 1'b0;
        end else if (acc_x || acc_y) begin
            m_valid_q <= 1'b1;
            m_data_q  <= acc_y ? y_data : x_data;
            m_src_q   <= acc_y;
        end else if (m_ready) begin
            m_valid_q <= 1'b0;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_src   = m_src_q;
    assign busy    = m_valid_q || x_valid || y_valid;

`ifdef MUX2_ARB_CNT_EN
    logic [CNT_W-1:0] x_cnt_q, y_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            x_cnt_q <= '0;
            y_cnt_q <= '0;
        end else begin
            if (acc_x) x_cnt_q <= x_cnt_q + CNT_W'(1);
            if (acc_y) y_cnt_q <= y_cnt_q + CNT_W'(1);
        end
    end

    assign x_cnt = x_cnt_q;
    assign y_cnt = y_cnt_q;
`endif

endmodule

// File: tb/tb_mux2_rr_arbiter_8bit.sv
// Directed bench for mux2_rr_arbiter_8bit: round-robin order, backpressure, reset, early handover.
module tb_mux2_rr_arbiter_8bit;

    logic       clk = 1'b0;
    logic       rst;
    logic       x_valid, y_valid, m_ready;
    logic [7:0] x_data, y_data;
    logic       x_ready, y_ready, m_valid, m_src, busy;
    logic [7:0] m_data;
`ifdef MUX2_ARB_CNT_EN
    logic [7:0] x_cnt, y_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mux2_rr_arbiter_8bit #(.BURST_LEN(2), .CNT_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .x_valid (x_valid),
        .x_data  (x_data),
        .x_ready (x_ready),
        .y_valid (y_valid),
        .y_data  (y_data),
        .y_ready (y_ready),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_src   (m_src),
        .m_ready (m_ready),
`ifdef MUX2_ARB_CNT_EN
        .x_cnt   (x_cnt),
        .y_cnt   (y_cnt),
`endif
        .busy    (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp_d [5];
        logic       exp_s [5];

        rst = 1'b1; x_valid = 1'b0; y_valid = 1'b0; m_ready = 1'b0;
        x_data = 8'h00; y_data = 8'h00;
        cyc();
        x_valid = 1'b1;
        #1;
        chk("rst_x_ready", {31'd0, x_ready}, 32'd0);
        cyc();
        x_valid = 1'b0;
        #1;
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_m_data",  {24'd0, m_data},  32'h00);
        chk("rst_m_src",   {31'd0, m_src},   32'd0);
        chk("rst_busy",    {31'd0, busy},    32'd0);

        // Round-robin with BURST_LEN=2: X,X,Y,Y,X
        rst = 1'b0; x_valid = 1'b1; y_valid = 1'b1; m_ready = 1'b1;
        x_data = 8'h12; y_data = 8'h34;
        exp_d = '{8'h12, 8'h12, 8'h34, 8'h34, 8'h12};
        exp_s = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        #1;
        chk("rr_m_valid_pre", {31'd0, m_valid}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("rr_x_ready_%0d", i), {31'd0, x_ready}, {31'd0, !exp_s[i]});
            chk($sformatf("rr_y_ready_%0d", i), {31'd0, y_ready}, {31'd0, exp_s[i]});
            cyc();
            chk($sformatf("rr_m_valid_%0d", i), {31'd0, m_valid}, 32'd1);
            chk($sformatf("rr_m_data_%0d", i),  {24'd0, m_data},  {24'd0, exp_d[i]});
            chk($sformatf("rr_m_src_%0d", i),   {31'd0, m_src},   {31'd0, exp_s[i]});
        end
        x_valid = 1'b0; y_valid = 1'b0;
        cyc();
        chk("rr_drain", {31'd0, m_valid}, 32'd0);

        // Only Y valid
        y_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            y_data = 8'(i);
            #1;
            chk($sformatf("yonly_x_ready_%0d", i), {31'd0, x_ready}, 32'd0);
            chk($sformatf("yonly_y_ready_%0d", i), {31'd0, y_ready}, 32'd1);
            cyc();
            chk($sformatf("yonly_m_data_%0d", i), {24'd0, m_data}, i);
            chk($sformatf("yonly_m_src_%0d", i),  {31'd0, m_src}, 32'd1);
        end
        y_valid = 1'b0;
        cyc();
        chk("yonly_drain", {31'd0, m_valid}, 32'd0);

        // Backpressure holds A5 and freezes grants
        x_valid = 1'b1; x_data = 8'hA5;
        cyc();
        chk("bp_first", {24'd0, m_data}, 32'hA5);
        m_ready = 1'b0; y_valid = 1'b1; x_data = 8'h77; y_data = 8'h88;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("bp_x_ready_%0d", i), {31'd0, x_ready}, 32'd0);
            chk($sformatf("bp_y_ready_%0d", i), {31'd0, y_ready}, 32'd0);
            cyc();
            chk($sformatf("bp_hold_data_%0d", i),  {24'd0, m_data}, 32'hA5);
            chk($sformatf("bp_hold_valid_%0d", i), {31'd0, m_valid}, 32'd1);
            chk($sformatf("bp_hold_src_%0d", i),   {31'd0, m_src}, 32'd0);
        end
        m_ready = 1'b1;
        #1;
        chk("bp_resume_x_ready", {31'd0, x_ready}, 32'd1);
        chk("bp_resume_y_ready", {31'd0, y_ready}, 32'd0);
        chk("bp_busy", {31'd0, busy}, 32'd1);
        cyc();
        chk("bp_next_data", {24'd0, m_data}, 32'h77);
        x_valid = 1'b0; y_valid = 1'b0;
        cyc();
        chk("bp_drain", {31'd0, m_valid}, 32'd0);

        // Reset while holding 5A
        y_valid = 1'b1; y_data = 8'h5A;
        cyc();
        chk("rstmid_held", {24'd0, m_data}, 32'h5A);
        m_ready = 1'b0; y_valid = 1'b0; rst = 1'b1;
        #1;
        chk("rstmid_y_ready", {31'd0, y_ready}, 32'd0);
        cyc();
        chk("rstmid_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rstmid_m_data",  {24'd0, m_data},  32'h00);
        rst = 1'b0; m_ready = 1'b1;
        x_valid = 1'b1; y_valid = 1'b1; x_data = 8'hC3; y_data = 8'h3C;
        #1;
        chk("rstmid_tie_x_ready", {31'd0, x_ready}, 32'd1);
        chk("rstmid_tie_y_ready", {31'd0, y_ready}, 32'd0);
        cyc();
        chk("rstmid_tie_data", {24'd0, m_data}, 32'hC3);
        chk("rstmid_tie_src",  {31'd0, m_src},  32'd0);

        // X drops in OWN_X with burst=1: Y granted at once
        x_valid = 1'b0;
        #1;
        chk("drop_y_ready", {31'd0, y_ready}, 32'd1);
        chk("drop_x_ready", {31'd0, x_ready}, 32'd0);
        cyc();
        chk("drop_data", {24'd0, m_data}, 32'h3C);
        chk("drop_src",  {31'd0, m_src},  32'd1);
        y_valid = 1'b0;
        cyc();
        chk("drop_drain_valid", {31'd0, m_valid}, 32'd0);
        chk("drop_drain_busy",  {31'd0, busy},    32'd0);

`ifdef MUX2_ARB_CNT_EN
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("cnt_rst_x", {24'd0, x_cnt}, 32'd0);
        chk("cnt_rst_y", {24'd0, y_cnt}, 32'd0);
        x_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            x_data = 8'(i);
            cyc();
            if (i == 254) chk("cnt_x_ff", {24'd0, x_cnt}, 32'hFF);
        end
        x_valid = 1'b0; y_valid = 1'b1;
        for (int i = 0; i < 3; i++) cyc();
        y_valid = 1'b0;
        chk("cnt_x_wrap", {24'd0, x_cnt}, 32'h00);
        chk("cnt_y",      {24'd0, y_cnt}, 32'h03);
        cyc();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
